// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus-arbiter test system.
// Holds the server FSM state encoding and the default widths
// that the arbiter's client-side models also use.
package bus_arb_pkg;

  localparam int DEF_LAT_W = 4;
  localparam int DEF_CNT_W = 16;

  // Encoding 2'b11 is deliberately left unused; the FSM recovers it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } srv_state_t;

endpackage

// File: rtl/service_timer.sv
// Loadable down-counter that models the programmed service delay.
// The terminal flag is raised while the count sits at one, so the owner
// can leave its wait state on the same edge the last cycle expires.
module service_timer #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_value,
  input  logic             enable,
  output logic             cnt_eq_one
);

  logic [LAT_W-1:0] count_q;

  // Load has priority over decrement; the count holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable) begin
      count_q <= count_q - LAT_W'(1);
    end
  end

  assign cnt_eq_one = (count_q == LAT_W'(1));

endmodule

// File: rtl/bus_server_responder.sv
// Server-side endpoint of the arbiter's four-phase rq/ack handshake.
// Accepts a request, waits a programmable number of cycles, acknowledges,
// and returns to zero once the arbiter drops its request. Completions are
// counted and early request drops raise a sticky error flag.
module bus_server_responder
  import bus_arb_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             server_rq,
  output logic             server_ack,
  input  logic [LAT_W-1:0] latency,
  input  logic             err_clr,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] txn_count
);

  srv_state_t state_q, state_d;
  logic       ack_d;
  logic       set_err;
  logic       inc_count;
  logic       timer_load;
  logic       timer_en;
  logic       timer_one;

  service_timer #(
    .LAT_W (LAT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (latency),
    .enable     (timer_en),
    .cnt_eq_one (timer_one)
  );

  // State, acknowledge, error flag and completion counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      server_ack <= 1'b0;
      proto_err  <= 1'b0;
      txn_count  <= '0;
    end else begin
      state_q    <= state_d;
      server_ack <= ack_d;
      if (set_err) begin
        proto_err <= 1'b1;
      end else if (err_clr) begin
        proto_err <= 1'b0;
      end
      if (inc_count) begin
        txn_count <= txn_count + CNT_W'(1);
      end
    end
  end

  // Next-state and next-output decode; latency is only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    set_err    = 1'b0;
    inc_count  = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (server_rq) begin
          if (latency == '0) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            state_d    = BUSY;
            timer_load = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!server_rq) begin
          state_d = IDLE;
          set_err = 1'b1;
        end else if (timer_one) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      ACK: begin
        if (server_rq) begin
          ack_d = 1'b1;
        end else begin
          state_d   = IDLE;
          inc_count = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bus_server_responder.sv
// Directed testbench for bus_server_responder, built with a 2-bit
// transaction counter so the wrap can be reached in a few transactions.
module tb_bus_server_responder;

  localparam int LAT_W = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             server_rq;
  logic             server_ack;
  logic [LAT_W-1:0] latency;
  logic             err_clr;
  logic             busy;
  logic             proto_err;
  logic [CNT_W-1:0] txn_count;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  bus_server_responder #(
    .LAT_W (LAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .server_rq  (server_rq),
    .server_ack (server_ack),
    .latency    (latency),
    .err_clr    (err_clr),
    .busy       (busy),
    .proto_err  (proto_err),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  // Advance across one rising edge; inputs change and outputs are sampled at negedge.
  task automatic go();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; server_rq = 1'b0; latency = '0; err_clr = 1'b0;
    go(); go();
    checks++;
    if (server_ack !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0 || txn_count !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: ack=%b busy=%b err=%b cnt=%0d required 0 0 0 0",
               server_ack, busy, proto_err, txn_count);
    end
    reset = 1'b0;
    go();
    server_rq = 1'b1; latency = 4'd5;
    go(); go();
    checks++;
    if (busy !== 1'b1 || server_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_pre_busy: busy=%b ack=%b required 1 0", busy, server_ack);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (server_ack !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0 || txn_count !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_busy: ack=%b busy=%b err=%b cnt=%0d required 0 0 0 0",
               server_ack, busy, proto_err, txn_count);
    end
    server_rq = 1'b0;
    go();
    reset = 1'b0;
    go();
  endtask

  // Accept a request with latency lat, optionally reprogram latency during service,
  // check ack rises exactly lat edges after acceptance, then release.
  task automatic test_latency(input logic [LAT_W-1:0] lat, input logic [LAT_W-1:0] new_lat,
                              input string name);
    server_rq = 1'b1; latency = lat;
    go();
    latency = new_lat;
    checks++;
    if (server_ack !== (lat == 0)) begin
      failures++;
      $display("[TB] FAIL %s_accept: ack=%b required %b", name, server_ack, (lat == 0));
    end
    for (int j = 1; j <= int'(lat); j++) begin
      go();
      checks++;
      if (server_ack !== (j == int'(lat)) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s_edge%0d: ack=%b busy=%b required %b 1",
                 name, j, server_ack, busy, (j == int'(lat)));
      end
    end
    go();
    checks++;
    if (server_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_hold: ack=%b required 1", name, server_ack);
    end
    server_rq = 1'b0;
    go();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (server_ack !== 1'b0 || busy !== 1'b0 || txn_count !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL %s_release: ack=%b busy=%b cnt=%0d required 0 0 %0d",
               name, server_ack, busy, txn_count, exp_cnt);
    end
    go();
  endtask

  task automatic test_abort();
    server_rq = 1'b1; latency = 4'd6;
    go(); go();
    server_rq = 1'b0;
    go();
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b0 || server_ack !== 1'b0 || txn_count !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL abort: err=%b busy=%b ack=%b cnt=%0d required 1 0 0 %0d",
               proto_err, busy, server_ack, txn_count, exp_cnt);
    end
    err_clr = 1'b1;
    go();
    err_clr = 1'b0;
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_clear: err=%b required 0", proto_err);
    end
    server_rq = 1'b1; latency = 4'd2;
    go();
    server_rq = 1'b0; err_clr = 1'b1;
    go();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL set_beats_clear: err=%b required 1", proto_err);
    end
    go();
    err_clr = 1'b0;
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_clear2: err=%b required 0", proto_err);
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    go();
    reset = 1'b0;
    exp_cnt = '0;
    latency = '0;
    for (int n = 0; n < 3; n++) begin
      server_rq = 1'b1;
      go();
      checks++;
      if (server_ack !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_ack%0d: ack=%b required 1", n, server_ack);
      end
      server_rq = 1'b0;
      go();
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (server_ack !== 1'b0 || txn_count !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL b2b_rel%0d: ack=%b cnt=%0d required 0 %0d",
                 n, server_ack, txn_count, exp_cnt);
      end
    end
    checks++;
    if (txn_count !== 2'd3) begin
      failures++;
      $display("[TB] FAIL b2b_total: cnt=%0d required 3", txn_count);
    end
  endtask

  task automatic test_wrap();
    server_rq = 1'b1; latency = '0;
    go();
    server_rq = 1'b0;
    go();
    checks++;
    if (txn_count !== 2'd0) begin
      failures++;
      $display("[TB] FAIL wrap: cnt=%0d required 0", txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_latency(4'd5, 4'd5, "post_reset_l5");
    test_latency(4'd0, 4'd0, "lat0");
    test_latency(4'd3, 4'd3, "lat3");
    test_latency(4'd4, 4'd1, "lat_change");
    test_abort();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_server_responder.md
# bus_server_responder

Server-side endpoint of the arbiter's rq/ack bus handshake. It accepts `server_rq` from the arbiter and models a service delay that software can program. It then drives `server_ack` under a four-phase (return-to-zero) protocol. Completed and aborted transactions are counted and flagged for debug. The block sits behind the bus arbiter and stands in for the shared resource, both in the bus-arbiter test system and as a reusable model for other clients.

## Interface

Parameters:
- LAT_W, 4, width of the service-latency input.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset; asynchronous, active-high.
- server_rq  in  1  request from the arbiter; level signal, four-phase protocol.
- server_ack  out  1  acknowledge to the arbiter; registered.
- latency  in  LAT_W  service delay in cycles; sampled only when a request is accepted.
- err_clr  in  1  synchronous clear of `proto_err`.
- busy  out  1  high while a transaction is in service or being acknowledged.
- proto_err  out  1  sticky flag; set when the request drops before acknowledge.
- txn_count  out  CNT_W  number of completed transactions; wraps modulo 2^CNT_W.

## Operation

States:
- IDLE (2'b00)
- BUSY (2'b01)
- ACK (2'b10)
- Encoding 2'b11 is unreachable and recovers to IDLE with `server_ack` = 0.

Transitions from IDLE:
- If `server_rq` = 1 and `latency` = 0: go to ACK and set `server_ack` <= 1.
- If `server_rq` = 1 and `latency` != 0: go to BUSY and load the timer with `latency`.
- Otherwise stay in IDLE.

Transitions from BUSY:
- If `server_rq` = 0: abort. Go to IDLE, set `proto_err` <= 1, leave `txn_count` unchanged.
- Else if timer = 1: go to ACK and set `server_ack` <= 1.
- Else: decrement the timer.

Transitions from ACK:
- `server_ack` stays 1 while `server_rq` = 1.
- When `server_rq` is sampled 0: set `server_ack` <= 0, increment `txn_count` (wrapping), go to IDLE.

Other rules:
- `busy` = (state != IDLE), decoded from the state register only, so it is glitch-free.
- `latency` changes while in BUSY or ACK have no effect on the current transaction.
- `proto_err`: `err_clr` clears it. If set and clear occur in the same cycle, set wins.
- `txn_count` wraps from all-ones to 0 with no flag.

## Timing

- Reset values: `server_ack` = 0, `busy` = 0, `proto_err` = 0, `txn_count` = 0, state IDLE, timer = 0.
- Reset asserted mid-transaction returns everything to reset values immediately. No count is recorded and no error is flagged.
- Latency definition: let k be the edge that samples `server_rq` = 1 in IDLE. `server_ack` rises at edge k + L, where L is the `latency` sampled at edge k. With L = 0, `server_ack` rises at edge k, so the arbiter sees it one cycle after presenting the request.
- Release: `server_ack` falls on the first edge that samples `server_rq` = 0 in ACK. `txn_count` updates on that same edge.
- Back-to-back transactions: a new request can be accepted on the edge after the release edge. Minimum full transaction with L = 0 is 2 edges in state (IDLE→ACK→IDLE). Throughput is therefore one transaction every 2 cycles.
- All outputs are registered, except `busy`, which is decoded from the state flops.

## Structure

- Shared package `bus_arb_pkg` holds:
  - the state encoding constants IDLE/BUSY/ACK;
  - the default widths LAT_W = 4 and CNT_W = 16, shared with the arbiter's client-side models.
- One sub-module is natural: `service_timer`, a loadable LAT_W down-counter.
  - Inputs: load, load value, enable.
  - Output: the terminal flag `cnt_eq_one`.
- FSM, ack register, error flag and transaction counter stay in the top module.

## Test plan

- Reset: assert `reset` mid-BUSY with L = 5 → all outputs 0 immediately. After release, the next request acknowledges after the full 5 cycles.
- Latency 0 and 3: `server_rq` high at edge k.
  - L = 0 → `server_ack` high after edge k.
  - L = 3 → `server_ack` high after edge k+3.
  - Then drop `server_rq` → `server_ack` low next edge and `txn_count` increments by 1.
- Latency change ignored: accept with L = 4, then drive `latency` = 1 during BUSY → `server_ack` still rises at k+4.
- Abort: L = 6, drop `server_rq` at k+2 → IDLE, `proto_err` = 1, `txn_count` unchanged. Assert `err_clr` → `proto_err` = 0. Set and clear in the same cycle → `proto_err` = 1.
- Back-to-back: 3 transactions with L = 0 and `server_rq` re-raised immediately after each ack release → one completion every 2 cycles, `txn_count` = 3.
- Wrap: preload by running 2^CNT_W completions (or use CNT_W = 2 in the bench) → `txn_count` returns to 0 after the all-ones value.
